// File: rtl/shadow_reg_ctrl.sv
// Shadowed register write sequencer: a value commits only after two identical back-to-back writes.
// Optional STAGED expiry timer is enabled by defining SHADOW_REG_CTRL_TIMEOUT_EN.
module shadow_reg_ctrl #(
  parameter int unsigned     DW      = 5,
  parameter logic [DW-1:0]   RESVAL  = DW'(24),
  parameter int unsigned     MAX_ERR = 3,
  parameter int unsigned     TIMEOUT = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             wr_valid_i,
  output logic                             wr_ready_o,
  input  logic [DW-1:0]                    wr_data_i,
  input  logic                             rd_i,
  output logic [DW-1:0]                    q_o,
  output logic                             qe_o,
  output logic                             phase_o,
  output logic                             err_update_o,
  output logic [$clog2(MAX_ERR+1)-1:0]     err_cnt_o,
  output logic                             locked_o
);

  localparam int unsigned EW = $clog2(MAX_ERR + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STAGED = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] staged_q, staged_d;
  logic [DW-1:0] q_q, q_d;
  logic          qe_q, qe_d;
  logic          err_upd_q, err_upd_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic          accept;
  logic          locked;
  logic          err_event;

`ifdef SHADOW_REG_CTRL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          expired;
  assign expired = (tmo_q == TW'(TIMEOUT - 1));
`endif

  assign wr_ready_o = (state_q != COMMIT);
  assign accept     = wr_valid_i && wr_ready_o;
  assign locked     = (err_cnt_q == EW'(MAX_ERR));

  always_comb begin
    state_d   = state_q;
    staged_d  = staged_q;
    q_d       = q_q;
    qe_d      = 1'b0;
    err_upd_d = 1'b0;
    err_event = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Once locked, accepted writes are swallowed and the FSM never leaves IDLE.
        if (accept && !locked) begin
          staged_d = wr_data_i;
          state_d  = STAGED;
        end
      end
      STAGED: begin
        if (rd_i) begin
          if (accept) begin
            staged_d = wr_data_i;
          end else begin
            staged_d = '0;
            state_d  = IDLE;
          end
        end else if (accept) begin
          staged_d = '0;
          if (wr_data_i == staged_q) begin
            q_d     = wr_data_i;
            qe_d    = 1'b1;
            state_d = COMMIT;
          end else begin
            err_event = 1'b1;
            state_d   = IDLE;
          end
        end
`ifdef SHADOW_REG_CTRL_TIMEOUT_EN
        else if (expired) begin
          staged_d  = '0;
          err_event = 1'b1;
          state_d   = IDLE;
        end
`endif
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    err_upd_d = err_event;
    err_cnt_d = err_cnt_q;
    if (err_event && !locked) begin
      err_cnt_d = err_cnt_q + EW'(1);
    end
  end

`ifdef SHADOW_REG_CTRL_TIMEOUT_EN
  // Any accepted write in STAGED either leaves the state or restarts the stage.
  always_comb begin
    tmo_d = '0;
    if (state_q == STAGED && state_d == STAGED && !accept) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      staged_q  <= '0;
      q_q       <= RESVAL;
      qe_q      <= 1'b0;
      err_upd_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      staged_q  <= staged_d;
      q_q       <= q_d;
      qe_q      <= qe_d;
      err_upd_q <= err_upd_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign q_o          = q_q;
  assign qe_o         = qe_q;
  assign phase_o      = (state_q == STAGED);
  assign err_update_o = err_upd_q;
  assign err_cnt_o    = err_cnt_q;
  assign locked_o     = locked;

endmodule

// File: tb/tb_shadow_reg_ctrl.sv
// Bench for shadow_reg_ctrl: directed vector table, timeout corner sequences, and random traffic vs. a reference model.
module tb_shadow_reg_ctrl;

  localparam int MAXE = 3;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, vld = 1'b0, rd = 1'b0;
  logic [4:0] dat = '0;
  logic       rdy, qe, ph, err, lk;
  logic [4:0] q;
  logic [1:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shadow_reg_ctrl #(
    .DW(5), .RESVAL(5'b11000), .MAX_ERR(MAXE), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(vld), .wr_ready_o(rdy),
    .wr_data_i(dat), .rd_i(rd), .q_o(q), .qe_o(qe), .phase_o(ph),
    .err_update_o(err), .err_cnt_o(cnt), .locked_o(lk)
  );

  // Observed/expected vector: {ready, q[4:0], qe, phase, err, cnt[1:0], locked}
  typedef struct {
    logic        rst_n;
    logic        vld;
    logic [4:0]  dat;
    logic        rd;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [11:0] obs();
    return {rdy, q, qe, ph, err, cnt, lk};
  endfunction

  task automatic add(input logic r, input logic v, input logic [4:0] d, input logic rr,
                     input logic e_rdy, input logic [4:0] e_q, input logic e_qe, input logic e_ph,
                     input logic e_err, input logic [1:0] e_cnt, input logic e_lk);
    vec_t t;
    t.rst_n = r; t.vld = v; t.dat = d; t.rd = rr;
    t.exp   = {e_rdy, e_q, e_qe, e_ph, e_err, e_cnt, e_lk};
    tbl.push_back(t);
  endtask

  task automatic drive(input logic r, input logic v, input logic [4:0] d, input logic rr);
    rst_n = r; vld = v; dat = d; rd = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %03h (rdy,q,qe,ph,err,cnt,lk) required %03h", name, act, exp);
    end
  endtask

  // Reference model: a pending-stage queue holding at most one value, plus a bubble flag after commit.
  logic [4:0] m_pend[$];
  bit         m_bub;
  logic [4:0] m_q;
  bit         m_qe, m_err;
  int         m_cnt, m_age;

  task automatic model_step(input logic r, input logic v, input logic [4:0] d, input logic rr);
    bit acc;
    acc   = v && !m_bub;
    m_qe  = 0;
    m_err = 0;
    if (!r) begin
      m_pend.delete(); m_bub = 0; m_q = 5'd24; m_cnt = 0; m_age = 0;
    end else if (m_bub) begin
      m_bub = 0;
    end else if (m_cnt == MAXE) begin
      // locked: everything is discarded
    end else if (m_pend.size() == 0) begin
      if (acc) begin m_pend.push_back(d); m_age = 0; end
    end else if (rr) begin
      m_pend.delete();
      if (acc) begin m_pend.push_back(d); m_age = 0; end
    end else if (acc) begin
      if (d == m_pend[0]) begin
        m_q = d; m_qe = 1; m_bub = 1;
      end else begin
        m_err = 1; m_cnt = (m_cnt + 1 > MAXE) ? MAXE : m_cnt + 1;
      end
      m_pend.delete();
    end else begin
`ifdef SHADOW_REG_CTRL_TIMEOUT_EN
      if (m_age == TMO - 1) begin
        m_pend.delete(); m_err = 1; m_cnt = (m_cnt + 1 > MAXE) ? MAXE : m_cnt + 1;
      end else begin
        m_age++;
      end
`endif
    end
  endtask

  function automatic logic [11:0] m_obs();
    return {!m_bub, m_q, m_qe, m_pend.size() != 0, m_err, 2'(m_cnt), m_cnt == MAXE};
  endfunction

  initial begin
    logic       r, v, rr;
    logic [4:0] d;
    bit         tmo_en;
`ifdef SHADOW_REG_CTRL_TIMEOUT_EN
    tmo_en = 1;
`else
    tmo_en = 0;
`endif

    //  rst vld dat  rd | rdy q   qe ph er cnt lk
    add(0, 0, 5'd0,  0,  1, 5'd24, 0, 0, 0, 2'd0, 0);
    add(1, 1, 5'd7,  0,  1, 5'd24, 0, 1, 0, 2'd0, 0);
    add(1, 1, 5'd7,  0,  0, 5'd7,  1, 0, 0, 2'd0, 0);
    add(1, 1, 5'd3,  0,  1, 5'd7,  0, 0, 0, 2'd0, 0);
    add(1, 0, 5'd0,  0,  1, 5'd7,  0, 0, 0, 2'd0, 0);
    add(0, 0, 5'd0,  0,  1, 5'd24, 0, 0, 0, 2'd0, 0);
    add(1, 1, 5'd7,  0,  1, 5'd24, 0, 1, 0, 2'd0, 0);
    add(1, 1, 5'd6,  0,  1, 5'd24, 0, 0, 1, 2'd1, 0);
    add(1, 0, 5'd0,  0,  1, 5'd24, 0, 0, 0, 2'd1, 0);
    add(1, 1, 5'd10, 0,  1, 5'd24, 0, 1, 0, 2'd1, 0);
    add(1, 1, 5'd11, 1,  1, 5'd24, 0, 1, 0, 2'd1, 0);
    add(1, 1, 5'd11, 0,  0, 5'd11, 1, 0, 0, 2'd1, 0);
    add(1, 0, 5'd0,  0,  1, 5'd11, 0, 0, 0, 2'd1, 0);
    add(1, 1, 5'd2,  0,  1, 5'd11, 0, 1, 0, 2'd1, 0);
    add(1, 1, 5'd3,  0,  1, 5'd11, 0, 0, 1, 2'd2, 0);
    add(1, 1, 5'd4,  0,  1, 5'd11, 0, 1, 0, 2'd2, 0);
    add(1, 1, 5'd5,  0,  1, 5'd11, 0, 0, 1, 2'd3, 1);
    add(1, 1, 5'd1,  0,  1, 5'd11, 0, 0, 0, 2'd3, 1);
    add(1, 1, 5'd1,  0,  1, 5'd11, 0, 0, 0, 2'd3, 1);
    add(1, 0, 5'd0,  0,  1, 5'd11, 0, 0, 0, 2'd3, 1);
    add(0, 0, 5'd0,  0,  1, 5'd24, 0, 0, 0, 2'd0, 0);
    add(1, 1, 5'd9,  0,  1, 5'd24, 0, 1, 0, 2'd0, 0);
    add(1, 0, 5'd0,  1,  1, 5'd24, 0, 0, 0, 2'd0, 0);
    add(1, 0, 5'd0,  1,  1, 5'd24, 0, 0, 0, 2'd0, 0);
    add(1, 1, 5'd9,  0,  1, 5'd24, 0, 1, 0, 2'd0, 0);
    add(1, 1, 5'd9,  0,  0, 5'd9,  1, 0, 0, 2'd0, 0);
    add(1, 1, 5'd9,  0,  1, 5'd9,  0, 0, 0, 2'd0, 0);
    add(1, 1, 5'd9,  0,  1, 5'd9,  0, 1, 0, 2'd0, 0);
    add(1, 1, 5'd9,  0,  0, 5'd9,  1, 0, 0, 2'd0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].vld, tbl[i].dat, tbl[i].rd);
      chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
    end

    // Stage held for TIMEOUT idle cycles: expires only when the timer is built in.
    drive(0, 0, 5'd0, 0);
    drive(1, 1, 5'd3, 0);
    chk("tmo_stage", obs(), {1'b1, 5'd24, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0});
    for (int k = 1; k < TMO; k++) drive(1, 0, 5'd0, 0);
    chk("tmo_pre", obs(), {1'b1, 5'd24, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0});
    drive(1, 0, 5'd0, 0);
    if (tmo_en) chk("tmo_expire", obs(), {1'b1, 5'd24, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0});
    else        chk("tmo_hold",   obs(), {1'b1, 5'd24, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0});

    // Confirm accepted in the last possible cycle commits in either build.
    drive(0, 0, 5'd0, 0);
    drive(1, 1, 5'd3, 0);
    for (int k = 1; k < TMO; k++) drive(1, 0, 5'd0, 0);
    drive(1, 1, 5'd3, 0);
    chk("tmo_confirm_wins", obs(), {1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0});

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      r  = !((i == 0) || (m_cnt == MAXE && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 9) < 7);
      d  = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) d = 5'($urandom_range(0, 31));
      rr = ($urandom_range(0, 9) == 0);
      model_step(r, v, d, rr);
      drive(r, v, d, rr);
      chk($sformatf("rand%0d", i), obs(), m_obs());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
